cnu_serial: RTL



---
 rtl/cnu_serial.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cnu_serial.sv
// Serial min-sum check node unit.
// Accepts DC variable-to-check messages one per handshake, tracks the sign
// product, the two smallest saturated magnitudes and the position of the
// smallest, then emits DC check-to-variable messages one per handshake.
module cnu_serial #(
    parameter int IN_W   = 9,
    parameter int OUT_W  = 6,
    parameter int DC     = 6,
    parameter int OFFSET = 0,
    localparam int IDX_W = (DC > 1) ? $clog2(DC) : 1,
    localparam int MAXM  = (1 << (OUT_W - 1)) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  q_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] r_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] r_idx
);

    localparam int MAG_W = OUT_W - 1;
    localparam int WIDE_W = IN_W + 1;
    localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'(MAXM);
    localparam logic [MAG_W-1:0] MAG_OFF = MAG_W'(OFFSET);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DC - 1);

    typedef enum logic {ACC, EMIT} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic [MAG_W-1:0]  min1, min1_nxt;
    logic [MAG_W-1:0]  min2, min2_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DC-1:0]     sgn_reg, sgn_reg_nxt;
    logic              sgn_prod, sgn_prod_nxt;
    logic [OUT_W-1:0]  r_out_nxt;
    logic [IDX_W-1:0]  r_idx_nxt;
    logic [MAG_W-1:0]  mag_in;
    logic [MAG_W-1:0]  m_sel;
    logic              neg_sel;

    // |q| clamped to the largest representable output magnitude; the extra
    // bit keeps the most negative input from wrapping back to itself.
    function automatic logic [MAG_W-1:0] sat_mag(input logic [IN_W-1:0] q);
        logic [WIDE_W-1:0] wide;
        wide = q[IN_W-1] ? (WIDE_W'(0) - {q[IN_W-1], q}) : {1'b0, q};
        if (wide > WIDE_W'(MAXM))
            sat_mag = MAG_MAX;
        else
            sat_mag = wide[MAG_W-1:0];
    endfunction

    // Offset correction floored at zero, then sign application; a zero
    // magnitude stays zero whatever the sign.
    function automatic logic [OUT_W-1:0] signed_out(input logic [MAG_W-1:0] m,
                                                    input logic neg);
        logic [MAG_W-1:0] mo;
        mo = (m > MAG_OFF) ? (m - MAG_OFF) : '0;
        signed_out = neg ? (OUT_W'(0) - {1'b0, mo}) : {1'b0, mo};
    endfunction

    assign mag_in    = sat_mag(q_in);
    assign in_ready  = (state == ACC);
    assign out_valid = (state == EMIT);

    // Next-state, accumulation and the next registered output value.
    // The output is computed from the post-update values so that r_out is
    // already correct in the first EMIT cycle and holds during a stall.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        min1_nxt     = min1;
        min2_nxt     = min2;
        idx_nxt      = idx;
        sgn_reg_nxt  = sgn_reg;
        sgn_prod_nxt = sgn_prod;
        m_sel        = '0;
        neg_sel      = 1'b0;
        r_out_nxt    = '0;
        r_idx_nxt    = '0;

        case (state)
            ACC: begin
                if (in_valid) begin
                    sgn_reg_nxt[cnt] = q_in[IN_W-1];
                    sgn_prod_nxt     = sgn_prod ^ q_in[IN_W-1];
                    if (mag_in < min1) begin
                        min2_nxt = min1;
                        min1_nxt = mag_in;
                        idx_nxt  = cnt;
                    end else if (mag_in < min2) begin
                        min2_nxt = mag_in;
                    end
                    if (cnt == LAST) begin
                        state_nxt = EMIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (cnt == LAST) begin
                        state_nxt    = ACC;
                        cnt_nxt      = '0;
                        min1_nxt     = MAG_MAX;
                        min2_nxt     = MAG_MAX;
                        idx_nxt      = '0;
                        sgn_prod_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = ACC;
        endcase

        if (state_nxt == EMIT) begin
            m_sel     = (cnt_nxt == idx_nxt) ? min2_nxt : min1_nxt;
            neg_sel   = sgn_prod_nxt ^ sgn_reg_nxt[cnt_nxt];
            r_out_nxt = signed_out(m_sel, neg_sel);
            r_idx_nxt = cnt_nxt;
        end
    end

    // State, accumulators and registered outputs; reset drops any partial check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACC;
            cnt      <= '0;
            min1     <= MAG_MAX;
            min2     <= MAG_MAX;
            idx      <= '0;
            sgn_reg  <= '0;
            sgn_prod <= 1'b0;
            r_out    <= '0;
            r_idx    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            min1     <= min1_nxt;
            min2     <= min2_nxt;
            idx      <= idx_nxt;
            sgn_reg  <= sgn_reg_nxt;
            sgn_prod <= sgn_prod_nxt;
            r_out    <= r_out_nxt;
            r_idx    <= r_idx_nxt;
        end
    end

endmodule
